// File: rtl/window_filter_stream.sv
// window_filter_stream: raster-order 3x3 filter (pass / gaussian / laplacian-abs) with zero padding,
// valid/ready on both sides and a three-stage window -> arithmetic -> output pipeline.
module window_filter_stream #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             frame_done
);
    localparam int N  = IMG_W * IMG_H;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int SL = 2 * IMG_W + 3;
    localparam int GW = PIX_W + 4;
    localparam int SW = PIX_W + 5;

    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN, DONE} state_t;

    state_t           st, st_n;
    logic             live;
    logic [1:0]       fm;
    logic [IW-1:0]    in_idx;
    logic [RW-1:0]    o_r, w_r;
    logic [CW-1:0]    o_c, w_c;
    logic [PIX_W-1:0] sr [SL];
    logic             w_v, a_v, a_l, m_v, m_l;
    logic [PIX_W-1:0] a_d, m_d, f_d;
    logic             adv, beat, step, produce, o_end;
    logic [PIX_W-1:0] p [9];
    logic [GW-1:0]    g;
    logic [SW-1:0]    nb, v, av;

    // The whole pipeline moves together; it only stalls when the output register cannot drain.
    assign adv        = en && !(m_v && !m_ready);
    assign s_ready    = live && adv && (st == IDLE || st == FILL || st == RUN);
    assign m_valid    = m_v && en;
    assign m_data     = m_d;
    assign m_last     = m_l;
    assign frame_done = en && st == DONE;
    assign beat       = s_valid && s_ready;
    assign step       = adv && st == FLUSH;
    assign produce    = (beat && in_idx >= IW'(IMG_W + 1)) || step;
    assign o_end      = o_r == RW'(IMG_H - 1) && o_c == CW'(IMG_W - 1);

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = beat ? FILL : IDLE;
            FILL:    st_n = (beat && in_idx == IW'(IMG_W + 1)) ? RUN : FILL;
            RUN:     st_n = (beat && in_idx == IW'(N - 1)) ? FLUSH : RUN;
            FLUSH:   st_n = (step && o_end) ? DRAIN : FLUSH;
            DRAIN:   st_n = (m_valid && m_ready && m_l) ? DONE : DRAIN;
            DONE:    st_n = en ? IDLE : DONE;
            default: st_n = IDLE;
        endcase
    end

    // sr[0] is the newest pixel; the window centre sits W+1 pixels back.
    always_comb begin
        g  = '0;
        nb = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                p[dr*3+dc] = ((dr == 0 && w_r == '0) || (dr == 2 && w_r == RW'(IMG_H - 1)) ||
                              (dc == 0 && w_c == '0) || (dc == 2 && w_c == CW'(IMG_W - 1)))
                             ? '0 : sr[(2-dr)*IMG_W + 2 - dc];
        for (int i = 0; i < 9; i++) begin
            g  = g + (GW'(p[i]) << ((i == 4) ? 2 : (i % 2)));
            nb = nb + ((i == 4) ? '0 : SW'(p[i]));
        end
        v   = (SW'(p[4]) << 3) - nb;
        av  = v[SW-1] ? -v : v;
        f_d = fm == 2'd1 ? PIX_W'(g >> 4) :
              fm == 2'd2 ? (av > SW'((1 << PIX_W) - 1) ? '1 : av[PIX_W-1:0]) : p[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            live   <= 1'b0;
            fm     <= '0;
            in_idx <= '0;
            o_r    <= '0;
            o_c    <= '0;
            w_r    <= '0;
            w_c    <= '0;
            w_v    <= 1'b0;
            a_v    <= 1'b0;
            a_l    <= 1'b0;
            a_d    <= '0;
            m_v    <= 1'b0;
            m_l    <= 1'b0;
            m_d    <= '0;
            for (int i = 0; i < SL; i++) sr[i] <= '0;
        end else if (en) begin
            st   <= st_n;
            live <= 1'b1;
            if (beat && st == IDLE) fm <= mode == 2'd3 ? 2'd0 : mode;
            if (beat) in_idx <= in_idx == IW'(N - 1) ? '0 : in_idx + IW'(1);
            if (beat || step) begin
                sr[0] <= beat ? s_data : '0;
                for (int i = 1; i < SL; i++) sr[i] <= sr[i-1];
            end
            if (adv) begin
                w_v <= produce;
                a_v <= w_v;
                a_l <= w_v && w_r == RW'(IMG_H - 1) && w_c == CW'(IMG_W - 1);
                a_d <= f_d;
                m_v <= a_v;
                m_l <= a_l;
                m_d <= a_d;
            end
            if (produce) begin
                w_r <= o_r;
                w_c <= o_c;
                o_c <= o_c == CW'(IMG_W - 1) ? '0 : o_c + CW'(1);
                if (o_c == CW'(IMG_W - 1)) o_r <= o_r == RW'(IMG_H - 1) ? '0 : o_r + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_window_filter_stream.sv
// tb_window_filter_stream: table vectors plus a queue scoreboard fed by a direct 2-D reference model.
module tb_window_filter_stream;
    localparam int W = 4, H = 4, N = W * H;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, s_valid = 1'b0, m_ready = 1'b1;
    logic       s_ready, m_valid, m_last, frame_done;
    logic [1:0] mode = 2'd0;
    logic [7:0] s_data = 8'd0, m_data;

    window_filter_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {int md; int val; int r; int c; int exp;} vec_t;

    int         n_chk = 0, n_fail = 0, n_out = 0;
    bit         tog = 1'b0, done_seen = 1'b0, prev_stall = 1'b0, last_prev = 1'b0;
    logic [7:0] prev_data;
    logic [7:0] img [N];
    logic [7:0] got [N];
    logic [7:0] sb [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_px(input int md, input int r, input int c);
        int s = 0, n = 0, v;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                int rr, cc, pv;
                rr = r + dr;
                cc = c + dc;
                pv = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? int'(img[rr*W+cc]) : 0;
                s += pv * ((dr == 0 && dc == 0) ? 4 : (dr == 0 || dc == 0) ? 2 : 1);
                if (dr != 0 || dc != 0) n += pv;
            end
        v = 8 * int'(img[r*W+c]) - n;
        if (v < 0) v = -v;
        return md == 1 ? s / 16 : md == 2 ? (v > 255 ? 255 : v) : int'(img[r*W+c]);
    endfunction

    initial forever begin
        @(posedge clk);
        #1 m_ready = tog ? !m_ready : 1'b1;
    end

    // Output monitor: samples on the falling edge what the next rising edge will transfer.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            n_out = 0;
            prev_stall = 1'b0;
            last_prev = 1'b0;
        end else begin
            if (en) begin
                chk("frame_done", frame_done, last_prev);
                if (frame_done) done_seen = 1'b1;
            end
            if (en && prev_stall) chk("hold", {m_valid, m_data}, {1'b1, prev_data});
            prev_stall = en && m_valid && !m_ready;
            prev_data  = m_data;
            last_prev  = en && m_valid && m_ready && m_last;
            if (en && m_valid && m_ready) begin
                if (sb.size() == 0) chk("extra_out", sb.size(), 1);
                else chk("data", m_data, sb.pop_front());
                chk("m_last", m_last, n_out == N - 1);
                if (n_out < N) got[n_out] = m_data;
                n_out++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit gaps);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_ready && en) break;
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        if (t == 200) chk("accept_timeout", t, 0);
    endtask

    task automatic run_frame(input int md, input bit gaps, input int pause_at, input int rst_at,
                             input bit chk_flush);
        int t;
        done_seen = 1'b0;
        n_out = 0;
        for (int k = 0; k < N; k++) sb.push_back(8'(ref_px(md, k / W, k % W)));
        mode = 2'(md);
        for (int i = 0; i < N; i++) begin
            if (i == 3 && pause_at >= 0) mode = (md == 1) ? 2'd2 : 2'd1;
            if (i == pause_at) begin
                en = 1'b0;
                @(negedge clk);
                chk("en_low", {s_ready, m_valid}, 0);
                repeat (5) @(posedge clk);
                #1 en = 1'b1;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                s_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("reset_outs", {s_ready, m_valid, m_last, frame_done, m_data}, 0);
                end
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            send(img[i], gaps);
        end
        if (chk_flush) repeat (5) begin
            @(negedge clk);
            chk("flush_s_ready", s_ready, 0);
        end
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done_seen) break;
        end
        chk("frame_done_seen", done_seen, 1);
        chk("out_count", n_out, N);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        tbl = '{'{1, 16, 0, 0, 9},   '{1, 16, 0, 1, 12},  '{1, 16, 1, 1, 16},  '{1, 16, 3, 3, 9},
                '{2, 10, 0, 0, 50},  '{2, 10, 0, 1, 30},  '{2, 10, 1, 1, 0},   '{2, 10, 3, 2, 30},
                '{2, 100, 0, 0, 255}, '{2, 100, 1, 0, 255}, '{2, 100, 2, 2, 0}, '{2, 100, 3, 3, 255}};
        repeat (2) begin
            @(negedge clk);
            chk("reset_outs", {s_ready, m_valid, m_last, frame_done, m_data}, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) img[i] = 8'(i);
        run_frame(0, 1'b0, -1, -1, 1'b1);
        for (int j = 0; j < 12; j++) begin
            if (j == 0 || tbl[j].md != tbl[j-1].md || tbl[j].val != tbl[j-1].val) begin
                for (int i = 0; i < N; i++) img[i] = 8'(tbl[j].val);
                run_frame(tbl[j].md, 1'b0, -1, -1, 1'b0);
            end
            chk("table", got[tbl[j].r*W+tbl[j].c], tbl[j].exp);
        end
        for (int i = 0; i < N; i++) img[i] = 8'(i * 13);
        tog = 1'b1;
        run_frame(1, 1'b1, -1, -1, 1'b0);
        tog = 1'b0;
        @(posedge clk);
        #1;
        run_frame(1, 1'b0, 7, -1, 1'b0);
        run_frame(1, 1'b0, -1, 9, 1'b0);
        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(0, 1'b0, -1, -1, 1'b0);
        for (int i = 0; i < N; i++) chk("fresh", got[i], img[i]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/window_filter_stream.md
Name: window_filter_stream

Overview:
- Parametrised successor to the fixed 64x64 parallel filter.
- Raster-order pixel stream in, same-size filtered stream out. A 3x3 window is built from two internal line buffers, with zero padding outside the image.
- Runtime-selectable kernel mode and valid/ready handshakes on both sides. Sits between the frame source (memory/DMA) and the pixel sink.

Parameters:
IMG_W, 64, image width in pixels (>=4)
IMG_H, 64, image height in lines (>=3)
PIX_W, 8, pixel bit width (4..16)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when low all state frozen
mode  in  2  kernel select: 0 pass, 1 gaussian, 2 laplacian-abs, 3 reserved (treated as 0)
s_valid  in  1  input pixel valid
s_ready  out  1  block accepts input pixel
s_data  in  PIX_W  input pixel, raster order
m_valid  out  1  output pixel valid
m_ready  in  1  sink accepts output pixel
m_data  out  PIX_W  filtered pixel
m_last  out  1  high with last output pixel (H-1,W-1) of the frame
frame_done  out  1  one-cycle pulse after m_last beat transfers

Behaviour:
- Reset: all outputs 0, state IDLE, line buffers and window cleared, counters 0. Reset mid-frame aborts the frame with no residual outputs.
- en=0: no transfers. s_ready and m_valid are forced 0. All registers hold. Resuming continues exactly where the block stopped.
- Transfers:
  - Input beat when s_valid&s_ready&en; output beat when m_valid&m_ready&en.
  - m_valid/m_data/m_last hold until accepted.
- States:
  - IDLE: s_ready=1. First input beat latches mode for the whole frame, then go to FILL. Later mode changes are ignored until the next IDLE.
  - FILL: accept inputs, no outputs, until input index W+1 (pixel (1,1)) is accepted, then RUN.
  - RUN: output index k is produced when input index k+W+1 is accepted. s_ready = !(output register full & !m_ready), i.e. input stalls under backpressure. Acceptance of input index W*H-1 goes to FLUSH.
  - FLUSH: s_ready=0. Emit the remaining W+1 outputs using zero for out-of-image rows and columns, one per beat under m_ready.
  - DONE: m_last beat transferred; pulse frame_done for 1 cycle, then IDLE.
- Pipeline: window register -> arithmetic register -> output register. m_valid for output k rises exactly 2 cycles after its enabling input beat (or flush step) when unstalled.
- Window: pixel (r,c) uses rows r-1..r+1 and cols c-1..c+1. Any coordinate outside 0..H-1 or 0..W-1 reads 0, including column wrap across line ends.
- Arithmetic, with p = 3x3 window and centre p11:
  - mode 0: out = p11.
  - mode 1: weights 1 2 1 / 2 4 2 / 1 2 1. Sum is PIX_W+4 bits unsigned; out = sum>>4 (floor, no rounding).
  - mode 2: v = 8*p11 - sum of the 8 neighbours, signed PIX_W+5 bits; out = min(|v|, 2^PIX_W-1).
- m_last is asserted only on output index W*H-1.
- Back-to-back frames: a new frame may begin on the cycle after frame_done.

Test Plan:
- W=H=4, PIX_W=8, mode 0, input ramp 0..15 with s_valid always 1 and m_ready always 1 -> outputs 0..15 in order; m_last on value 15; frame_done pulse one cycle later; s_ready=0 for the 5 flush beats.
- mode 1, all pixels 16 -> corner (0,0)=9, edge (0,1)=12, interior (1,1)=16, corner (3,3)=9.
- mode 2, all pixels 10 -> corner=50, edge=30, interior=0. Repeat with all pixels 100 -> corner and edge clamp to 255, interior 0.
- mode 1 ramp with m_ready toggling 1010... and s_valid random -> output sequence identical to the unstalled run; no dropped or duplicated beats; m_data stable while m_valid&!m_ready.
- en=0 for 5 cycles at input index 7, mode changed during the frame -> output identical to the uninterrupted run with the original mode.
- Reset asserted at input index 9, then a fresh mode 0 frame -> all outputs 0 during reset; new frame output equals its input exactly, with no stale pixels from the aborted frame.
